// File: rtl/wb_rr_arbiter2_if.sv
// Pipelined Wishbone bus bundle used on both sides of wb_rr_arbiter2.
//   master modport : drives cyc/stb/we/adr/sel/dat_w, receives dat_r/ack/err/stall
//   slave  modport : the mirror image
// dat_w carries write data toward the slave, dat_r carries read data back.
interface wb_rr_arbiter2_if #(
  parameter int AW = 28,
  parameter int DW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;
  logic            stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_w,
    input  dat_r, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_w,
    output dat_r, ack, err, stall
  );
endinterface

// File: rtl/wb_rr_arbiter2.sv
// Two-master / one-slave pipelined Wishbone arbiter with round-robin grants
// (one transaction per grant) and a hang watchdog.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   m0, m1        : master-facing buses (slave modport)
//   s             : shared slave bus (master modport)
//   owner_o       : index of the master currently selected/owning the bus
//   timeout_o     : one-cycle pulse when the watchdog terminates a transaction

// Per-master response gating: only the selected master sees the slave's
// handshake; everyone else is stalled with no ack/err.
module wb_rr_arbiter2_resp (
  input  logic rst_n,
  input  logic is_sel,
  input  logic busy,
  input  logic s_ack,
  input  logic s_err,
  input  logic s_stall,
  input  logic fire,
  output logic stall,
  output logic ack,
  output logic err
);
  assign stall = ~rst_n | ~is_sel | s_stall;
  // ack/err only reach a master once it owns the bus; the accept cycle is IDLE.
  assign ack   = rst_n & is_sel & busy & s_ack;
  assign err   = rst_n & is_sel & busy & (s_err | fire);
endmodule

module wb_rr_arbiter2 #(
  parameter int AW             = 28,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  wb_rr_arbiter2_if.slave        m0,
  wb_rr_arbiter2_if.slave        m1,
  wb_rr_arbiter2_if.master       s,
  output logic                   owner_o,
  output logic                   timeout_o
);
  localparam int NM  = 2;
  localparam int SW  = DW / 8;
  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Watchdog fires on the cycle whose increment would reach TIMEOUT_CYCLES.
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               rr_last_q, rr_last_d;
  logic [WDW-1:0]     wdog_q, wdog_d;
  logic               accepted_q, accepted_d;

  logic [NM-1:0]          m_cyc, m_stb, m_we, req;
  logic [NM-1:0][AW-1:0]  m_adr;
  logic [NM-1:0][SW-1:0]  m_sel;
  logic [NM-1:0][DW-1:0]  m_dat;
  logic [NM-1:0]          m_stall, m_ack, m_err, is_sel;

  logic busy, grant_vld, winner, sel_m, fwd, count_en, fire, rel, accept;

  assign m_cyc = {m1.cyc, m0.cyc};
  assign m_stb = {m1.stb, m0.stb};
  assign m_we  = {m1.we, m0.we};
  assign m_adr = {m1.adr, m0.adr};
  assign m_sel = {m1.sel, m0.sel};
  assign m_dat = {m1.dat_w, m0.dat_w};
  assign req   = m_cyc & m_stb;

  // Arbitration: a single requester always wins; a tie goes against rr_last.
  assign busy      = (state_q == BUSY);
  assign grant_vld = |req;
  assign winner    = (&req) ? ~rr_last_q : req[1];
  assign sel_m     = busy ? owner_q : (grant_vld ? winner : owner_q);
  assign fwd       = busy | grant_vld;

  // Watchdog only runs once the slave has actually taken the strobe.
  assign count_en = busy & accepted_q & ~s.ack & ~s.err;
  assign fire     = (TIMEOUT_CYCLES != 0) & count_en & (wdog_q == WD_LAST);
  // Only the owner's cyc can end a grant; the waiting master is ignored.
  assign rel      = busy & (s.ack | s.err | ~m_cyc[owner_q] | fire);

  // Slave side: selected master passes through; a firing watchdog cuts cyc.
  assign s.cyc   = rst_ni & fwd & m_cyc[sel_m] & ~fire;
  assign s.stb   = rst_ni & fwd & m_stb[sel_m] & ~fire;
  assign s.we    = m_we[sel_m];
  assign s.adr   = m_adr[sel_m];
  assign s.sel   = m_sel[sel_m];
  assign s.dat_w = m_dat[sel_m];
  assign accept  = s.stb & ~s.stall;

  genvar k;
  generate
    for (k = 0; k < NM; k++) begin : g_resp
      assign is_sel[k] = fwd & (sel_m == 1'(k));
      wb_rr_arbiter2_resp u_resp (
        .rst_n   (rst_ni),
        .is_sel  (is_sel[k]),
        .busy    (busy),
        .s_ack   (s.ack),
        .s_err   (s.err),
        .s_stall (s.stall),
        .fire    (fire),
        .stall   (m_stall[k]),
        .ack     (m_ack[k]),
        .err     (m_err[k])
      );
    end
  endgenerate

  assign m0.stall = m_stall[0];
  assign m0.ack   = m_ack[0];
  assign m0.err   = m_err[0];
  assign m0.dat_r = s.dat_r;
  assign m1.stall = m_stall[1];
  assign m1.ack   = m_ack[1];
  assign m1.err   = m_err[1];
  assign m1.dat_r = s.dat_r;

  assign owner_o   = rst_ni & sel_m;
  assign timeout_o = rst_ni & fire;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_last_d  = rr_last_q;
    wdog_d     = wdog_q;
    accepted_d = accepted_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d    = BUSY;
          owner_d    = winner;
          rr_last_d  = winner;
          accepted_d = accept;
          wdog_d     = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          state_d    = IDLE;
          accepted_d = 1'b0;
          wdog_d     = '0;
        end else begin
          if (accept)   accepted_d = 1'b1;
          if (count_en) wdog_d     = wdog_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      wdog_q     <= '0;
      accepted_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_last_q  <= rr_last_d;
      wdog_q     <= wdog_d;
      accepted_q <= accepted_d;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Bench for wb_rr_arbiter2: arbitration table plus hand-written sequences;
// every master response is checked against a queue of expected responses.
module tb_wb_rr_arbiter2;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic owner_o, timeout_o;

  always #5 clk_i = ~clk_i;

  wb_rr_arbiter2_if #(.AW(28), .DW(32)) m0_bus ();
  wb_rr_arbiter2_if #(.AW(28), .DW(32)) m1_bus ();
  wb_rr_arbiter2_if #(.AW(28), .DW(32)) s_bus ();

  wb_rr_arbiter2 #(.AW(28), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .owner_o   (owner_o),
    .timeout_o (timeout_o)
  );

  typedef struct {
    int          m;
    bit          is_err;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    bit r0, r1;
    bit ex_owner, ex_cyc, ex_st0, ex_st1;
  } vec_t;

  exp_t sbq[$];
  exp_t mon_x;
  int   total = 0;
  int   bad   = 0;
  int   ack_cnt [2];

  logic [1:0]  r_ack, r_err;
  logic [31:0] r_dat [2];
  assign r_ack    = {m1_bus.ack, m0_bus.ack};
  assign r_err    = {m1_bus.err, m0_bus.err};
  assign r_dat[0] = m0_bus.dat_r;
  assign r_dat[1] = m1_bus.dat_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: any master ack/err must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int k = 0; k < 2; k++) begin
        if (r_ack[k] | r_err[k]) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp m%0d ack=%0b err=%0b want=none t=%0t",
                     k, r_ack[k], r_err[k], $time);
          end else begin
            mon_x = sbq.pop_front();
            chk("resp_master", k, mon_x.m);
            chk("resp_is_err", r_err[k], mon_x.is_err);
            if (!mon_x.is_err) chk("resp_dat", r_dat[k], mon_x.dat);
          end
          if (r_ack[k]) ack_cnt[k]++;
        end
      end
    end
  end

  task automatic set_m(input int m, input bit cyc, input bit stb, input bit we,
                       input logic [27:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
      m0_bus.adr = adr; m0_bus.sel = sel; m0_bus.dat_w = dat;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
      m1_bus.adr = adr; m1_bus.sel = sel; m1_bus.dat_w = dat;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called at the negedge of a granting IDLE cycle: record the expected ack,
  // let the grant edge pass, ack from the slave, then return to IDLE.
  task automatic finish_xfer(input int m, input logic [31:0] d);
    sbq.push_back('{m: m, is_err: 1'b0, dat: d});
    tick();
    set_m(m, 1, 0, 0, 28'h0, 4'h0, 32'h0);
    set_m(1 - m, 0, 0, 0, 28'h0, 4'h0, 32'h0);
    s_bus.ack = 1'b1; s_bus.dat_r = d;
    tick();
    s_bus.ack = 1'b0; s_bus.dat_r = 32'h0;
    set_m(m, 0, 0, 0, 28'h0, 4'h0, 32'h0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_s_cyc"}, s_bus.cyc, 0);
    chk({tag, "_s_stb"}, s_bus.stb, 0);
    chk({tag, "_m0_stall"}, m0_bus.stall, 1);
    chk({tag, "_m1_stall"}, m1_bus.stall, 1);
    chk({tag, "_m0_ack"}, m0_bus.ack, 0);
    chk({tag, "_m1_ack"}, m1_bus.ack, 0);
    chk({tag, "_m0_err"}, m0_bus.err, 0);
    chk({tag, "_owner"}, owner_o, 0);
    chk({tag, "_timeout"}, timeout_o, 0);
  endtask

  // Reset with both masters requesting and a stray slave ack, so gating is visible.
  task automatic do_reset();
    rst_ni = 1'b0;
    set_m(0, 1, 1, 0, 28'h1, 4'hF, 32'h0);
    set_m(1, 1, 1, 0, 28'h2, 4'hF, 32'h0);
    s_bus.ack = 1'b1; s_bus.err = 1'b0; s_bus.stall = 1'b0; s_bus.dat_r = 32'h0;
    @(negedge clk_i);
    chk_reset_outs("rst");
    tick();
    set_m(0, 0, 0, 0, 28'h0, 4'h0, 32'h0);
    set_m(1, 0, 0, 0, 28'h0, 4'h0, 32'h0);
    s_bus.ack = 1'b0;
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    vec_t tbl [8];
    int a0, a1;
    // Round-robin walk from reset (rr_last=1): {r0,r1} -> owner, s_cyc, stalls.
    tbl[0] = '{0, 0, 0, 0, 1, 1};
    tbl[1] = '{1, 0, 0, 1, 0, 1};
    tbl[2] = '{1, 0, 0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 1, 1, 0};
    tbl[4] = '{1, 1, 0, 1, 0, 1};
    tbl[5] = '{0, 1, 1, 1, 1, 0};
    tbl[6] = '{1, 1, 0, 1, 0, 1};
    tbl[7] = '{0, 0, 0, 0, 1, 1};
    ack_cnt[0] = 0; ack_cnt[1] = 0;

    do_reset();

    for (int i = 0; i < 8; i++) begin
      set_m(0, tbl[i].r0, tbl[i].r0, 0, 28'(32'h100 + i), 4'hF, 32'h0);
      set_m(1, tbl[i].r1, tbl[i].r1, 0, 28'(32'h200 + i), 4'hF, 32'h0);
      @(negedge clk_i);
      chk($sformatf("tbl%0d_owner", i), owner_o, tbl[i].ex_owner);
      chk($sformatf("tbl%0d_s_cyc", i), s_bus.cyc, tbl[i].ex_cyc);
      chk($sformatf("tbl%0d_m0_stall", i), m0_bus.stall, tbl[i].ex_st0);
      chk($sformatf("tbl%0d_m1_stall", i), m1_bus.stall, tbl[i].ex_st1);
      if (tbl[i].r0 | tbl[i].r1) begin
        chk($sformatf("tbl%0d_adr", i), s_bus.adr,
            tbl[i].ex_owner ? 28'(32'h200 + i) : 28'(32'h100 + i));
        finish_xfer(tbl[i].ex_owner, 32'hC0DE0000 | i);
      end else begin
        tick();
      end
    end

    // m0 read with one stall cycle, ack two cycles after acceptance.
    set_m(0, 1, 1, 0, 28'h0000100, 4'hF, 32'h0);
    s_bus.stall = 1'b1;
    @(negedge clk_i);
    chk("t1_s_stb", s_bus.stb, 1);
    chk("t1_s_adr", s_bus.adr, 28'h0000100);
    chk("t1_m0_stall_on", m0_bus.stall, 1);
    chk("t1_m1_stall_a", m1_bus.stall, 1);
    sbq.push_back('{m: 0, is_err: 1'b0, dat: 32'hDEADBEEF});
    tick();
    s_bus.stall = 1'b0;
    @(negedge clk_i);
    chk("t1_m0_stall_off", m0_bus.stall, 0);
    chk("t1_m1_stall_b", m1_bus.stall, 1);
    tick();
    set_m(0, 1, 0, 0, 28'h0000100, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t1_m1_stall_c", m1_bus.stall, 1);
    chk("t1_no_early_ack", m0_bus.ack, 0);
    tick();
    s_bus.ack = 1'b1; s_bus.dat_r = 32'hDEADBEEF;
    @(negedge clk_i);
    chk("t1_m0_ack", m0_bus.ack, 1);
    chk("t1_m1_stall_d", m1_bus.stall, 1);
    tick();
    s_bus.ack = 1'b0; s_bus.dat_r = 32'h0;
    @(negedge clk_i);
    chk("t1_idle_s_cyc", s_bus.cyc, 0);
    tick();
    set_m(0, 0, 0, 0, 28'h0, 4'h0, 32'h0);

    // m1 write while m0 idle.
    set_m(1, 1, 1, 1, 28'h0000040, 4'h3, 32'h12345678);
    @(negedge clk_i);
    chk("t3_we", s_bus.we, 1);
    chk("t3_sel", s_bus.sel, 4'h3);
    chk("t3_dat", s_bus.dat_w, 32'h12345678);
    chk("t3_adr", s_bus.adr, 28'h0000040);
    chk("t3_owner", owner_o, 1);
    finish_xfer(1, 32'h0);

    // Watchdog: slave accepts but never acks; late ack must be dropped.
    set_m(0, 1, 1, 0, 28'h0000300, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t4_owner", owner_o, 0);
    sbq.push_back('{m: 0, is_err: 1'b1, dat: 32'h0});
    tick();
    set_m(0, 1, 0, 0, 28'h0000300, 4'hF, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      chk($sformatf("t4_timeout_c%0d", k), timeout_o, (k == 8));
      chk($sformatf("t4_m0_err_c%0d", k), m0_bus.err, (k == 8));
    end
    chk("t4_s_cyc_cut", s_bus.cyc, 0);
    tick();
    set_m(0, 0, 0, 0, 28'h0, 4'h0, 32'h0);
    @(negedge clk_i);
    chk("t4_timeout_clear", timeout_o, 0);
    tick();
    tick();
    s_bus.ack = 1'b1;
    @(negedge clk_i);
    chk("t4_late_m0_ack", m0_bus.ack, 0);
    chk("t4_late_m1_ack", m1_bus.ack, 0);
    tick();
    s_bus.ack = 1'b0;

    // Both masters request continuously: owners alternate 0,1,0,1.
    do_reset();
    a0 = ack_cnt[0]; a1 = ack_cnt[1];
    set_m(0, 1, 1, 0, 28'h0000500, 4'hF, 32'h0);
    set_m(1, 1, 1, 0, 28'h0000600, 4'hF, 32'h0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      chk($sformatf("t2_owner_%0d", n), owner_o, n % 2);
      chk($sformatf("t2_win_stall_%0d", n), (n % 2) ? m1_bus.stall : m0_bus.stall, 0);
      chk($sformatf("t2_lose_stall_%0d", n), (n % 2) ? m0_bus.stall : m1_bus.stall, 1);
      sbq.push_back('{m: n % 2, is_err: 1'b0, dat: 32'hA0000000 | n});
      tick();
      set_m(n % 2, 1, 0, 0, (n % 2) ? 28'h0000600 : 28'h0000500, 4'hF, 32'h0);
      s_bus.ack = 1'b1; s_bus.dat_r = 32'hA0000000 | n;
      tick();
      s_bus.ack = 1'b0; s_bus.dat_r = 32'h0;
      if (n == 3) begin
        set_m(0, 0, 0, 0, 28'h0, 4'h0, 32'h0);
        set_m(1, 0, 0, 0, 28'h0, 4'h0, 32'h0);
      end else begin
        set_m(n % 2, 1, 1, 0, (n % 2) ? 28'h0000600 : 28'h0000500, 4'hF, 32'h0);
      end
    end
    @(negedge clk_i);
    chk("t2_m0_acks", ack_cnt[0] - a0, 2);
    chk("t2_m1_acks", ack_cnt[1] - a1, 2);

    // Reset mid-BUSY with ack pending; m0 wins first afterwards.
    set_m(0, 1, 1, 0, 28'h0000700, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t5_m0_grant", m0_bus.stall, 0);
    tick();
    set_m(0, 1, 0, 0, 28'h0000700, 4'hF, 32'h0);
    set_m(1, 1, 1, 0, 28'h0000800, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t5_m1_held", m1_bus.stall, 1);
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    s_bus.ack = 1'b1; s_bus.dat_r = 32'h55AA55AA;
    #1;
    chk_reset_outs("t5_rst");
    tick();
    tick();
    rst_ni = 1'b1;
    s_bus.ack = 1'b0; s_bus.dat_r = 32'h0;
    set_m(0, 1, 1, 0, 28'h0000700, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t5_owner_after", owner_o, 0);
    chk("t5_m0_stall", m0_bus.stall, 0);
    chk("t5_m1_stall", m1_bus.stall, 1);
    finish_xfer(0, 32'h0BADF00D);

    // Owner m1 aborts; waiting m0 is granted right after.
    set_m(1, 1, 1, 0, 28'h0000900, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t6_owner_m1", owner_o, 1);
    chk("t6_m1_stall", m1_bus.stall, 0);
    tick();
    set_m(1, 1, 0, 0, 28'h0000900, 4'hF, 32'h0);
    set_m(0, 1, 1, 0, 28'h0000A00, 4'hF, 32'h0);
    @(negedge clk_i);
    chk("t6_busy_owner", owner_o, 1);
    chk("t6_m0_held", m0_bus.stall, 1);
    tick();
    set_m(1, 0, 0, 0, 28'h0, 4'h0, 32'h0);
    @(negedge clk_i);
    chk("t6_abort_s_cyc", s_bus.cyc, 0);
    chk("t6_m1_ack", m1_bus.ack, 0);
    chk("t6_m1_err", m1_bus.err, 0);
    tick();
    @(negedge clk_i);
    chk("t6_m0_owner", owner_o, 0);
    chk("t6_m0_stall", m0_bus.stall, 0);
    chk("t6_m0_s_cyc", s_bus.cyc, 1);
    finish_xfer(0, 32'h600D600D);

    tick();
    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
